// File: rtl/phase_seq.sv
// rtl/phase_seq.sv - wash-cycle phase sequencer (wash/rinse/dry sub-phase walker with unit counters)
module phase_seq #(
  parameter int WAS_U = 9,
  parameter int RIN_U = 6,
  parameter int DRA_U = 3,
  parameter int SPI_U = 3,
  parameter int DRY_U = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       tr_run,
  input  logic       abort,
  input  logic [2:0] prog,
  input  logic [5:0] u_wat,
  output logic       busy,
  output logic       paused,
  output logic [2:0] ld_drw,
  output logic [2:0] ld_fsd,
  output logic [5:0] u_rem,
  output logic [5:0] u_stg,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  // Slots 0-2 wash fil/agi/dra, 3-6 rinse fil/agi/dra/spi, 7 dry.
  function automatic logic slot_sel(input logic [2:0] s, input logic [2:0] p);
    if (s <= 3'd2)      return p[0];
    else if (s <= 3'd6) return p[1];
    else                return p[2];
  endfunction

  function automatic logic [3:0] find_slot(input logic [3:0] from, input logic [2:0] p);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--)
      if (4'(i) >= from && slot_sel(3'(i), p)) r = 4'(i);
    return r;
  endfunction

  function automatic logic [5:0] slot_len(input logic [2:0] s, input logic [3:0] f);
    case (s)
      3'd0, 3'd3: return {2'b00, f};
      3'd1:       return 6'(WAS_U);
      3'd2, 3'd5: return 6'(DRA_U);
      3'd4:       return 6'(RIN_U);
      3'd6:       return 6'(SPI_U);
      default:    return 6'(DRY_U);
    endcase
  endfunction

  function automatic logic [2:0] slot_drw(input logic [2:0] s);
    if (s <= 3'd2)      return 3'b001;
    else if (s <= 3'd6) return 3'b010;
    else                return 3'b100;
  endfunction

  function automatic logic [2:0] slot_fsd(input logic [2:0] s);
    case (s)
      3'd0, 3'd3: return 3'b100;
      3'd2, 3'd5: return 3'b001;
      3'd6:       return 3'b010;
      default:    return 3'b000;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [2:0] prog_q, prog_d;
  logic [3:0] fil_q, fil_d;
  logic [2:0] slot_q, slot_d;
  logic       busy_q, busy_d, paused_q, paused_d, done_q, done_d;
  logic [2:0] ld_drw_q, ld_drw_d, ld_fsd_q, ld_fsd_d;
  logic [5:0] u_rem_q, u_rem_d, u_stg_q, u_stg_d;

  logic [3:0] fil_in;
  logic [3:0] first_slot, next_slot;
  logic [7:0] total_in;

  assign fil_in     = (u_wat == 6'd0) ? 4'd1 : (u_wat > 6'd15) ? 4'd15 : u_wat[3:0];
  assign first_slot = find_slot(4'd0, prog);
  assign next_slot  = find_slot({1'b0, slot_q} + 4'd1, prog_q);
  assign total_in   = (prog[0] ? 8'(fil_in) + 8'(WAS_U + DRA_U) : 8'd0)
                    + (prog[1] ? 8'(fil_in) + 8'(RIN_U + DRA_U + SPI_U) : 8'd0)
                    + (prog[2] ? 8'(DRY_U) : 8'd0);

  always_comb begin
    state_d  = state_q;
    prog_d   = prog_q;
    fil_d    = fil_q;
    slot_d   = slot_q;
    busy_d   = busy_q;
    paused_d = paused_q;
    ld_drw_d = ld_drw_q;
    ld_fsd_d = ld_fsd_q;
    u_rem_d  = u_rem_q;
    u_stg_d  = u_stg_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && prog != 3'b000) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          prog_d   = prog;
          fil_d    = fil_in;
          slot_d   = first_slot[2:0];
          u_stg_d  = slot_len(first_slot[2:0], fil_in);
          ld_drw_d = slot_drw(first_slot[2:0]);
          ld_fsd_d = slot_fsd(first_slot[2:0]);
          u_rem_d  = total_in[5:0];
        end
      end
      S_RUN: begin
        if (abort || (tick && !tr_run && u_rem_q == 6'd1)) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          paused_d = 1'b0;
          slot_d   = 3'd0;
          ld_drw_d = 3'b000;
          ld_fsd_d = 3'b000;
          u_rem_d  = 6'd0;
          u_stg_d  = 6'd0;
          done_d   = !abort;
        end else if (tr_run) begin
          state_d  = S_PAUSE;
          paused_d = 1'b1;
        end else if (tick) begin
          u_rem_d = u_rem_q - 6'd1;
          if (u_stg_q == 6'd1) begin
            slot_d   = next_slot[2:0];
            u_stg_d  = slot_len(next_slot[2:0], fil_q);
            ld_drw_d = slot_drw(next_slot[2:0]);
            ld_fsd_d = slot_fsd(next_slot[2:0]);
          end else begin
            u_stg_d = u_stg_q - 6'd1;
          end
        end
      end
      default: begin
        if (abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          paused_d = 1'b0;
          slot_d   = 3'd0;
          ld_drw_d = 3'b000;
          ld_fsd_d = 3'b000;
          u_rem_d  = 6'd0;
          u_stg_d  = 6'd0;
        end else if (tr_run) begin
          state_d  = S_RUN;
          paused_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prog_q   <= 3'd0;
      fil_q    <= 4'd0;
      slot_q   <= 3'd0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      ld_drw_q <= 3'd0;
      ld_fsd_q <= 3'd0;
      u_rem_q  <= 6'd0;
      u_stg_q  <= 6'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prog_q   <= prog_d;
      fil_q    <= fil_d;
      slot_q   <= slot_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      ld_drw_q <= ld_drw_d;
      ld_fsd_q <= ld_fsd_d;
      u_rem_q  <= u_rem_d;
      u_stg_q  <= u_stg_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign paused = paused_q;
  assign ld_drw = ld_drw_q;
  assign ld_fsd = ld_fsd_q;
  assign u_rem  = u_rem_q;
  assign u_stg  = u_stg_q;
  assign done   = done_q;

endmodule

// File: tb/tb_phase_seq.sv
// tb/tb_phase_seq.sv - directed bench for phase_seq
module tb_phase_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, tr_run = 1'b0, abort = 1'b0;
  logic [2:0] prog = 3'd0;
  logic [5:0] u_wat = 6'd0;
  logic       busy, paused, done;
  logic [2:0] ld_drw, ld_fsd;
  logic [5:0] u_rem, u_stg;

  int passed = 0;
  int total  = 0;
  int done_seen = 0;

  phase_seq dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .tr_run(tr_run),
    .abort(abort), .prog(prog), .u_wat(u_wat), .busy(busy), .paused(paused),
    .ld_drw(ld_drw), .ld_fsd(ld_fsd), .u_rem(u_rem), .u_stg(u_stg), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input logic t, input logic tr, input logic ab, input logic st);
    @(negedge clk);
    tick = t; tr_run = tr; abort = ab; start = st;
    @(posedge clk);
    #1;
    tick = 1'b0; tr_run = 1'b0; abort = 1'b0; start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_paused"}, 32'(paused), 0);
    chk({tag, "_drw"}, 32'(ld_drw), 0);
    chk({tag, "_fsd"}, 32'(ld_fsd), 0);
    chk({tag, "_rem"}, 32'(u_rem), 0);
    chk({tag, "_stg"}, 32'(u_stg), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle("reset");

    // wash only, fill 4: 4 + 9 + 3 = 16
    prog = 3'b001; u_wat = 6'd4;
    step(0, 0, 0, 1);
    chk("w_busy", 32'(busy), 1);
    chk("w_rem", 32'(u_rem), 16);
    chk("w_stg", 32'(u_stg), 4);
    chk("w_drw", 32'(ld_drw), 3'b001);
    chk("w_fsd", 32'(ld_fsd), 3'b100);
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, 0);
      if (i == 4) begin
        chk("w_agi_fsd", 32'(ld_fsd), 0);
        chk("w_agi_stg", 32'(u_stg), 9);
        chk("w_agi_rem", 32'(u_rem), 12);
      end
      if (i == 13) begin
        chk("w_dra_fsd", 32'(ld_fsd), 3'b001);
        chk("w_dra_stg", 32'(u_stg), 3);
      end
      if (i == 15) chk("w_nodone", 32'(done), 0);
    end
    chk("w_done", 32'(done), 1);
    chk("w_end_busy", 32'(busy), 0);
    chk("w_end_rem", 32'(u_rem), 0);
    chk("w_end_drw", 32'(ld_drw), 0);
    step(0, 0, 0, 0);
    chk("w_done_1cyc", 32'(done), 0);
    chk("w_done_cnt", 32'(done_seen), 1);

    // all stages, fill clamped 20 -> 15
    prog = 3'b111; u_wat = 6'd20;
    step(0, 0, 0, 1);
    chk("a_rem", 32'(u_rem), 60);
    chk("a_stg", 32'(u_stg), 15);
    chk("a_drw", 32'(ld_drw), 3'b001);
    for (int i = 1; i <= 60; i++) begin
      step(1, 0, 0, 0);
      if (i == 27) begin
        chk("a_rin_drw", 32'(ld_drw), 3'b010);
        chk("a_rin_fsd", 32'(ld_fsd), 3'b100);
        chk("a_rin_stg", 32'(u_stg), 15);
        chk("a_rin_rem", 32'(u_rem), 33);
      end
      if (i == 51) begin
        chk("a_spi_fsd", 32'(ld_fsd), 3'b010);
        chk("a_spi_stg", 32'(u_stg), 3);
        chk("a_spi_rem", 32'(u_rem), 9);
      end
      if (i == 54) begin
        chk("a_dry_drw", 32'(ld_drw), 3'b100);
        chk("a_dry_fsd", 32'(ld_fsd), 0);
        chk("a_dry_stg", 32'(u_stg), 6);
        chk("a_dry_rem", 32'(u_rem), 6);
      end
    end
    chk("a_done", 32'(done), 1);
    chk("a_busy", 32'(busy), 0);
    step(0, 0, 0, 0);
    chk("a_done_cnt", 32'(done_seen), 2);

    // prog 000 ignored; abort in idle no effect
    prog = 3'b000; u_wat = 6'd5;
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk_idle("p0");

    // dry only, u_wat 0 unused
    prog = 3'b100; u_wat = 6'd0;
    step(0, 0, 0, 1);
    chk("d_rem", 32'(u_rem), 6);
    chk("d_stg", 32'(u_stg), 6);
    chk("d_drw", 32'(ld_drw), 3'b100);
    chk("d_fsd", 32'(ld_fsd), 0);
    prog = 3'b001; u_wat = 6'd9;
    step(0, 0, 0, 1);
    chk("d_restart_rem", 32'(u_rem), 6);
    chk("d_restart_drw", 32'(ld_drw), 3'b100);
    step(0, 0, 1, 0);
    chk_idle("d_abort");

    // pause / resume
    prog = 3'b001; u_wat = 6'd4;
    step(0, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0);
    chk("p_rem5", 32'(u_rem), 11);
    chk("p_stg5", 32'(u_stg), 8);
    step(0, 1, 0, 0);
    chk("p_paused", 32'(paused), 1);
    chk("p_busy", 32'(busy), 1);
    repeat (10) step(1, 0, 0, 0);
    chk("p_hold_rem", 32'(u_rem), 11);
    chk("p_hold_stg", 32'(u_stg), 8);
    chk("p_hold_fsd", 32'(ld_fsd), 0);
    step(1, 1, 0, 0);
    chk("p_resume", 32'(paused), 0);
    chk("p_resume_drop", 32'(u_rem), 11);
    step(1, 0, 0, 0);
    chk("p_run_rem", 32'(u_rem), 10);
    step(1, 1, 0, 0);
    chk("p_pause2", 32'(paused), 1);
    chk("p_pause2_drop", 32'(u_rem), 10);
    step(0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    chk("p_rem7", 32'(u_rem), 7);

    // abort with simultaneous tick at u_rem = 7
    step(1, 0, 1, 0);
    chk_idle("abort");
    repeat (3) step(1, 0, 0, 0);
    chk("abort_no_done", 32'(done_seen), 2);

    // async reset mid-run, then a full normal run
    step(0, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk_idle("rst_rel");
    step(0, 0, 0, 1);
    chk("r_rem", 32'(u_rem), 16);
    repeat (16) step(1, 0, 0, 0);
    chk("r_done", 32'(done), 1);
    step(0, 0, 0, 0);
    chk("r_done_cnt", 32'(done_seen), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
